// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI peripheral emulating a 12-bit serial ADC, serializing queued samples per cs frame.
module spi_adc_responder #(
  parameter int FRAME_BITS    = 16,
  parameter int LEADING_ZEROS = 4,
  parameter int DATA_BITS     = 12
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 chip_clk_in,
  input  logic                 chip_sel_in,
  output logic                 chip_data_out,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 sample_valid_in,
  output logic                 sample_ready_out,
  output logic                 frame_done_out,
  output logic                 underrun_out,
  output logic                 abort_out,
  output logic [15:0]          frame_count_out
);
  localparam int TAIL = FRAME_BITS - LEADING_ZEROS - DATA_BITS;
  localparam int CW   = $clog2(FRAME_BITS + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_d;
  logic prev_clk, prev_sel, hold_valid, hold_valid_d, data_d, done_d, under_d, abort_d;
  logic clk_rise, clk_fall, sel_rise, sel_fall, accept, take;
  logic [DATA_BITS-1:0] hold, hold_d, last_sample, last_d, pick;
  logic [FRAME_BITS-1:0] shift_reg, shift_d;
  logic [CW-1:0] rise_cnt, rise_d;
  logic [15:0] count_d;
  assign clk_rise = chip_clk_in & ~prev_clk;
  assign clk_fall = ~chip_clk_in & prev_clk;
  assign sel_rise = chip_sel_in & ~prev_sel;
  assign sel_fall = ~chip_sel_in & prev_sel;
  assign sample_ready_out = !hold_valid;
  assign accept = sample_valid_in && !hold_valid;
  assign take = state == IDLE && sel_fall;
  // a sample arriving in the very cycle cs falls bypasses the empty holding register
  assign pick = hold_valid ? hold : accept ? sample_in : last_sample;
  always_comb begin
    state_d = state;
    shift_d = shift_reg;
    rise_d = rise_cnt;
    last_d = last_sample;
    done_d = 1'b0;
    under_d = 1'b0;
    abort_d = 1'b0;
    count_d = frame_count_out;
    hold_valid_d = take ? 1'b0 : accept | hold_valid;
    hold_d = accept && !take ? sample_in : hold;
    if (take) begin
      state_d = SHIFT;
      shift_d = FRAME_BITS'(pick) << TAIL;
      last_d = pick;
      rise_d = '0;
      under_d = !hold_valid && !accept;
    end else if (state == SHIFT && sel_rise) begin
      state_d = IDLE;
      done_d = rise_cnt == CW'(FRAME_BITS);
      abort_d = !done_d;
      count_d = frame_count_out + 16'(done_d);
    end else if (state == SHIFT) begin
      rise_d = clk_rise && rise_cnt != CW'(FRAME_BITS) ? rise_cnt + 1'b1 : rise_cnt;
      shift_d = clk_fall ? shift_reg << 1 : shift_reg;
    end
    data_d = state_d == SHIFT && shift_d[FRAME_BITS-1];
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      prev_clk <= 1'b0;
      prev_sel <= 1'b0;
      hold <= '0;
      hold_valid <= 1'b0;
      last_sample <= '0;
      shift_reg <= '0;
      rise_cnt <= '0;
      chip_data_out <= 1'b0;
      frame_done_out <= 1'b0;
      underrun_out <= 1'b0;
      abort_out <= 1'b0;
      frame_count_out <= '0;
    end else begin
      state <= state_d;
      prev_clk <= chip_clk_in;
      prev_sel <= chip_sel_in;
      hold <= hold_d;
      hold_valid <= hold_valid_d;
      last_sample <= last_d;
      shift_reg <= shift_d;
      rise_cnt <= rise_d;
      chip_data_out <= data_d;
      frame_done_out <= done_d;
      underrun_out <= under_d;
      abort_out <= abort_d;
      frame_count_out <= count_d;
    end
  end
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: controller-driven reads checked against a queue-based ADC model.
module tb_spi_adc_responder;
  localparam int DCP = 5;
  logic clk = 0, rst = 1, dclk = 0, cs = 1, valid = 0;
  logic cipo, ready, done, under, abort_p;
  logic [11:0] sample = 0;
  logic [15:0] count;
  int checks = 0, errors = 0;
  int n_done = 0, n_under = 0, n_abort = 0;
  int m_done = 0, m_under = 0, m_abort = 0;
  logic [11:0] m_hold[$];
  logic [15:0] m_words[$];
  logic [11:0] m_last = 0, m_s;
  logic [15:0] m_count = 0;
  bit m_in = 0, m_pcs = 0, m_pclk = 0, m_acc;
  int m_rises = 0;
  logic [15:0] w, c0;
  int u0, a0;

  always #5 clk = ~clk;

  spi_adc_responder dut (
    .clk_in(clk), .rst_in(rst), .chip_clk_in(dclk), .chip_sel_in(cs),
    .chip_data_out(cipo), .sample_in(sample), .sample_valid_in(valid),
    .sample_ready_out(ready), .frame_done_out(done), .underrun_out(under),
    .abort_out(abort_p), .frame_count_out(count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ADC: one-deep pending queue, last-sample reuse, frame accounting by cs/dclk events
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_hold.delete(); m_words.delete();
      m_last = 0; m_count = 0; m_in = 0; m_rises = 0; m_pcs = 0; m_pclk = 0;
    end else begin
      m_acc = valid && m_hold.size() == 0;
      if (!m_in && m_pcs && !cs) begin
        if (m_hold.size() > 0) m_s = m_hold.pop_front();
        else if (m_acc) m_s = sample;
        else begin m_s = m_last; m_under++; end
        m_last = m_s;
        m_words.push_back({4'h0, m_s});
        m_in = 1; m_rises = 0;
      end else begin
        if (m_acc) m_hold.push_back(sample);
        if (m_in && !m_pcs && cs) begin
          if (m_rises >= 16) begin m_done++; m_count++; end
          else m_abort++;
          m_in = 0;
        end else if (m_in && !m_pclk && dclk) m_rises++;
      end
      m_pcs = cs; m_pclk = dclk;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      n_done += int'(done);
      n_under += int'(under);
      n_abort += int'(abort_p);
    end
  end

  task automatic push(input logic [11:0] v);
    bit ok = 0;
    @(negedge clk); sample = v; valid = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = ready;
      @(negedge clk);
    end
    valid = 0;
    check("push_accept", 32'(ok), 1);
  endtask

  task automatic clock_bits(input int n, inout logic [15:0] word);
    for (int i = 0; i < n; i++) begin
      repeat (DCP - 1) @(negedge clk);
      word = {word[14:0], cipo};
      dclk = 1;
      repeat (DCP) @(negedge clk);
      dclk = 0;
    end
  endtask

  task automatic do_read(input string tag, input int n, input bit byp, input logic [11:0] bv,
                         output logic [15:0] word);
    logic [15:0] exp, e;
    word = 0;
    @(negedge clk); cs = 0;
    if (byp) begin sample = bv; valid = 1; end
    @(negedge clk);
    if (byp) valid = 0;
    repeat (2) @(negedge clk);
    clock_bits(n, word);
    repeat (DCP) @(negedge clk); cs = 1;
    repeat (3) @(negedge clk);
    check({tag, "_queued"}, 32'(m_words.size()), 1);
    exp = m_words.size() > 0 ? m_words.pop_front() : 16'hxxxx;
    e = n <= 16 ? exp >> (16 - n) : exp << (n - 16);
    check({tag, "_word"}, 32'(word), 32'(e));
    check({tag, "_count"}, 32'(count), 32'(m_count));
    check({tag, "_done"}, n_done, m_done);
    check({tag, "_under"}, n_under, m_under);
    check({tag, "_abort"}, n_abort, m_abort);
    check({tag, "_ready"}, 32'(ready), 32'(m_hold.size() == 0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_cipo", 32'(cipo), 0);
    check("rst_ready", 32'(ready), 1);
    check("rst_count", 32'(count), 0);
    check("rst_pulses", {29'd0, done, under, abort_p}, 0);

    push(12'hABC);
    do_read("t1", 16, 0, 0, w);
    check("t1_const", 32'(w), 32'h0ABC);
    check("t1_cnt1", 32'(count), 1);

    push(12'h123);
    do_read("t2a", 16, 0, 0, w);
    u0 = n_under;
    do_read("t2b", 16, 0, 0, w);
    check("t2_const", 32'(w), 32'h0123);
    check("t2_one_under", n_under - u0, 1);

    u0 = n_under;
    do_read("t3", 16, 1, 12'hFFF, w);
    check("t3_const", 32'(w), 32'h0FFF);
    check("t3_no_under", n_under - u0, 0);
    check("t3_ready", 32'(ready), 1);

    a0 = n_abort; c0 = count;
    do_read("t4a", 7, 0, 0, w);
    check("t4_one_abort", n_abort - a0, 1);
    check("t4_count_kept", 32'(count), 32'(c0));
    push(12'h555);
    do_read("t4b", 16, 0, 0, w);
    check("t4_const", 32'(w), 32'h0555);

    push(12'h111);
    @(negedge clk); sample = 12'h222; valid = 1;
    repeat (3) @(negedge clk);
    check("t5_ready_full", 32'(ready), 0);
    do_read("t5a", 16, 0, 0, w);
    valid = 0;
    check("t5a_const", 32'(w), 32'h0111);
    do_read("t5b", 16, 0, 0, w);
    check("t5b_const", 32'(w), 32'h0222);

    push(12'hFFF);
    @(negedge clk); cs = 0;
    repeat (3) @(negedge clk);
    w = 0;
    clock_bits(5, w);
    check("t6_cipo_before", 32'(cipo), 1);
    @(negedge clk); rst = 1;
    #1;
    check("t6_rst_cipo", 32'(cipo), 0);
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_ready", 32'(ready), 1);
    cs = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    push(12'h800);
    do_read("t6", 16, 0, 0, w);
    check("t6_const", 32'(w), 32'h0800);

    for (int k = 0; k < 10; k++) begin
      int sel;
      if ($urandom_range(0, 1) == 1) push(12'($urandom));
      sel = $urandom_range(0, 3);
      do_read("rnd", sel == 0 ? 7 : sel == 3 ? 18 : 16, $urandom_range(0, 3) == 0, 12'($urandom), w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
